ram_boot_loader: RTL and testbench
==================================

// Module: ram_boot_loader
// PURPOSE
//  Upstream feeder for the 16-bit dual-port program/data RAM: takes a byte stream from the UART receiver and
//  packs it into 16-bit big-endian words, writing them into RAM port B.
//  Frame: SYNC(0xA5), LEN_HI, LEN_LO, then LEN words (hi byte first), then CHK. CHK = XOR of all bytes after SYNC.
//  Holds the CPU in reset (cpu_hold) while a frame is in flight. Lets the board be reprogrammed without resynthesis.
// PARAMETERS
//  DATA_WIDTH      16          RAM word width; fixed at 16 (two bytes per word)
//  ADDR_WIDTH      10          RAM address width; max frame LEN = 2**ADDR_WIDTH
//  BASE_ADDR       0           first RAM address written by a frame
//  TIMEOUT_CYCLES  50_000_000  max idle clocks between bytes inside a frame
// PORTS
//  clk          in   1           system clock, all logic on rising edge
//  reset        in   1           synchronous, active-high
//  rx_data      in   8           byte from UART receiver
//  rx_valid     in   1           rx_data valid; byte consumed when rx_valid & rx_ready
//  rx_ready     out  1           loader can accept a byte this cycle
//  data_b       out  DATA_WIDTH  RAM port-B write data
//  addr_b       out  ADDR_WIDTH  RAM port-B address
//  we_b         out  1           RAM port-B write enable, one-cycle pulse per word
//  cpu_hold     out  1           high while frame in progress (LEN_HI..CHK)
//  load_done    out  1           sticky: last frame completed with good checksum
//  load_error   out  1           sticky: last frame failed (checksum, length, timeout)
//  words_loaded out  ADDR_WIDTH+1  count of words written by the current or last frame
// BEHAVIOUR
//  Reset values: rx_ready=0, we_b=0, data_b=0, addr_b=BASE_ADDR, cpu_hold=0, load_done=0, load_error=0, words_loaded=0.
//  After reset, state goes to IDLE and rx_ready=1 from the next cycle.
//  States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERROR.
//   IDLE: any byte != 0xA5 is consumed and dropped. 0xA5 -> LEN_HI; clear chk, words_loaded, load_done, load_error.
//   LEN_HI/LEN_LO: latch the 16-bit length, then check it.
//     LEN==0 -> CHK.
//     LEN > 2**ADDR_WIDTH -> ERROR.
//     Otherwise -> DATA_HI.
//   DATA_HI: latch hi byte -> DATA_LO. DATA_LO: latch lo byte -> WRITE.
//   WRITE (exactly 1 cycle): rx_ready=0, we_b=1, data_b={hi,lo}, addr_b=BASE_ADDR+words_loaded (mod 2**ADDR_WIDTH).
//     Increment words_loaded. If words_loaded(new)==LEN -> CHK, else -> DATA_HI.
//     Latency: the write happens the cycle after the lo byte handshake.
//   CHK: byte==running XOR -> DONE, set load_done; else -> ERROR, set load_error.
//   DONE/ERROR: rx_ready=1; behave like IDLE (0xA5 starts a new frame, other bytes dropped).
//     Sticky flags hold until the next SYNC.
//  Checksum: 8-bit XOR over LEN_HI, LEN_LO and every data byte; updated on each accepted byte except SYNC and CHK.
//  cpu_hold=1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK; it drops in the same cycle DONE/ERROR is entered.
//  Timeout: the counter resets on every accepted byte and counts only in LEN_HI..CHK (not WRITE-gated).
//    Reaching TIMEOUT_CYCLES -> ERROR.
//  rx_ready=0 only in WRITE. rx_valid held across WRITE must be accepted on the following cycle (no byte lost).
//  BASE_ADDR + LEN overflowing the address space wraps mod 2**ADDR_WIDTH; no error.
//  Reset mid-frame: FSM and outputs return to reset values. RAM words already written remain.
//  Port A is untouched; the CPU must not write port B while cpu_hold=1.
// STRUCTURE
//  loader_pkg: state encoding localparams (IDLE..ERROR) and SYNC_BYTE=8'hA5.
//  Sub-module loader_timeout: counter with clear/enable inputs and an expired output.
//    Width $clog2(TIMEOUT_CYCLES+1).
//  The top level holds the FSM, byte latch, length register, XOR accumulator and address counter.
// TESTING
//  1 Frame A5 00 02 12 34 AB CD CHK=00^02^12^34^AB^CD:
//    addr_b=0/data_b=1234, then addr_b=1/data_b=ABCD, one we_b pulse each; load_done=1, words_loaded=2.
//  2 Same frame with CHK^1 -> both words written, load_error=1, load_done=0, cpu_hold=0.
//  3 LEN=0x0401 with ADDR_WIDTH=10 -> ERROR after LEN_LO, zero we_b pulses.
//  4 Stop after one data byte, TIMEOUT_CYCLES=100 -> load_error=1 exactly 100 cycles after the last accepted byte.
//  5 Garbage 00 FF 5A before SYNC is ignored, then a valid frame loads.
//    Reset asserted mid-DATA_LO -> we_b=0, cpu_hold=0 next cycle.
//  6 rx_valid held continuously (back-to-back bytes) -> rx_ready low only in WRITE cycles, all bytes land in order.

Source files
------------

// File: rtl/ram_boot_loader_pkg.sv
// Shared types for the RAM boot loader: FSM state encoding and the frame sync byte.
package ram_boot_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CHK,
    DONE,
    ERROR
  } state_t;

  // States between SYNC and the checksum byte, where the CPU is held and the timeout runs.
  function automatic logic in_frame(input state_t s);
    return s inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK};
  endfunction

endpackage

// File: rtl/ram_boot_loader_if.sv
// Byte-stream input from the UART receiver and write-only RAM port-B output of the boot loader.
interface ram_boot_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) ();

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] data_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic                  we_b;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, data_b, addr_b, we_b
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, data_b, addr_b, we_b
  );

endinterface

// File: rtl/ram_boot_loader_timeout.sv
// Inter-byte idle counter: expired is raised once TIMEOUT_CYCLES clocks pass with no clear while enabled.
module ram_boot_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear || !enable) begin
      count_reg <= '0;
    end else if (count_reg != LAST) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Firing on LAST lets the owner react on the TIMEOUT_CYCLES-th edge after the last byte.
  assign expired = enable && !clear && (count_reg == LAST);

endmodule

// File: rtl/ram_boot_loader.sv
// Packs a framed UART byte stream into 16-bit big-endian words and writes them to RAM port B.
module ram_boot_loader
  import ram_boot_loader_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 10,
  parameter int BASE_ADDR      = 0,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_boot_loader_if.master     bus,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_WIDTH);

  state_t              state_reg, state_next;
  logic                started_reg;
  logic [15:0]         len_reg, len_next;
  logic [7:0]          hi_reg, hi_next;
  logic [7:0]          lo_reg, lo_next;
  logic [7:0]          chk_reg, chk_next;
  logic [ADDR_WIDTH:0] words_reg, words_next;
  logic                done_reg, done_next;
  logic                error_reg, error_next;

  logic                accept;
  logic                timeout_expired;
  logic [15:0]         len_value;
  logic [ADDR_WIDTH:0] words_inc;

  assign bus.rx_ready = started_reg && (state_reg != WRITE);
  assign accept       = bus.rx_valid && bus.rx_ready;
  assign bus.we_b     = (state_reg == WRITE);
  assign bus.data_b   = {hi_reg, lo_reg};
  assign bus.addr_b   = ADDR_WIDTH'(BASE_ADDR) + words_reg[ADDR_WIDTH-1:0];
  assign cpu_hold     = in_frame(state_reg);
  assign load_done    = done_reg;
  assign load_error   = error_reg;
  assign words_loaded = words_reg;
  assign len_value    = {len_reg[15:8], bus.rx_data};
  assign words_inc    = words_reg + 1'b1;

  ram_boot_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (in_frame(state_reg)),
    .expired(timeout_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      started_reg <= 1'b0;
      len_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      chk_reg     <= '0;
      words_reg   <= '0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      started_reg <= 1'b1;
      len_reg     <= len_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      chk_reg     <= chk_next;
      words_reg   <= words_next;
      done_reg    <= done_next;
      error_reg   <= error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    chk_next   = chk_reg;
    words_next = words_reg;
    done_next  = done_reg;
    error_next = error_reg;

    if (in_frame(state_reg) && timeout_expired) begin
      state_next = ERROR;
      error_next = 1'b1;
    end else begin
      case (state_reg)
        IDLE, DONE, ERROR: begin
          if (accept && bus.rx_data == SYNC_BYTE) begin
            state_next = LEN_HI;
            chk_next   = '0;
            words_next = '0;
            done_next  = 1'b0;
            error_next = 1'b0;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len_next   = {bus.rx_data, 8'h00};
            chk_next   = chk_reg ^ bus.rx_data;
            state_next = LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len_next = len_value;
            chk_next = chk_reg ^ bus.rx_data;
            if (len_value == 16'd0) begin
              state_next = CHK;
            end else if ({1'b0, len_value} > MAX_LEN) begin
              state_next = ERROR;
              error_next = 1'b1;
            end else begin
              state_next = DATA_HI;
            end
          end
        end
        DATA_HI: begin
          if (accept) begin
            hi_next    = bus.rx_data;
            chk_next   = chk_reg ^ bus.rx_data;
            state_next = DATA_LO;
          end
        end
        DATA_LO: begin
          if (accept) begin
            lo_next    = bus.rx_data;
            chk_next   = chk_reg ^ bus.rx_data;
            state_next = WRITE;
          end
        end
        WRITE: begin
          words_next = words_inc;
          state_next = (17'(words_inc) == {1'b0, len_reg}) ? CHK : DATA_HI;
        end
        CHK: begin
          if (accept) begin
            if (bus.rx_data == chk_reg) begin
              state_next = DONE;
              done_next  = 1'b1;
            end else begin
              state_next = ERROR;
              error_next = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_boot_loader.sv
// Randomized frame bench: expected RAM writes are queued per frame and checked by a negedge monitor.
module tb_ram_boot_loader;

  localparam int AW   = 10;
  localparam int DW   = 16;
  localparam int BASE = 0;
  localparam int TMO  = 100;
  localparam int MAXW = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_hold, load_done, load_error;
  logic [AW:0]   words_loaded;

  ram_boot_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_boot_loader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [AW+DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  // Scoreboard: every RAM write must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      check("ready_only_low_in_write", 32'(bus.rx_ready), 32'(!bus.we_b));
      if (bus.we_b) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write got addr=%h data=%h required no write", bus.addr_b, bus.data_b);
        end else begin
          logic [AW+DW-1:0] e;
          e = exp_q.pop_front();
          check("write_addr", 32'(bus.addr_b), 32'(e[AW+DW-1:DW]));
          check("write_data", 32'(bus.data_b), 32'(e[DW-1:0]));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.rx_ready) break;
      n++;
      if (n > 20) begin
        checks++;
        errors++;
        $display("FAIL ready_wait got rx_ready=0 for 20 cycles required 1");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic maybe_gap(input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0) gap($urandom_range(1, 4));
  endtask

  task automatic do_reset();
    mon_en       = 1'b0;
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(bus.rx_ready), 32'd1);
    mon_en = 1'b1;
  endtask

  // Reference: a frame of len words loads iff len <= 2**AW; done iff also the checksum matches.
  task automatic run_frame(input int len, input logic [15:0] w[$], input bit bad, input bit gaps);
    logic [7:0]  chk;
    logic [15:0] l16;
    bit          fits, exp_done;
    l16  = 16'(len);
    fits = (len <= MAXW);
    chk  = l16[15:8] ^ l16[7:0];
    foreach (w[i]) chk ^= w[i][15:8] ^ w[i][7:0];
    if (bad) chk ^= 8'h01;
    if (fits) foreach (w[i]) exp_q.push_back({AW'((BASE + i) % MAXW), w[i]});
    exp_done = fits && !bad;

    send_byte(8'hA5);
    check("hold_in_frame", 32'(cpu_hold), 32'd1);
    maybe_gap(gaps);
    send_byte(l16[15:8]);
    maybe_gap(gaps);
    send_byte(l16[7:0]);
    if (fits) begin
      foreach (w[i]) begin
        maybe_gap(gaps);
        send_byte(w[i][15:8]);
        maybe_gap(gaps);
        send_byte(w[i][7:0]);
      end
      maybe_gap(gaps);
      send_byte(chk);
    end
    bus.rx_valid = 1'b0;
    check("load_done", 32'(load_done), 32'(exp_done));
    check("load_error", 32'(load_error), 32'(!exp_done));
    check("hold_released", 32'(cpu_hold), 32'd0);
    check("words_loaded", 32'(words_loaded), fits ? 32'(len) : 32'd0);
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    $display("frame len=%0d bad_chk=%0d gaps=%0d done=%0d error=%0d words=%0d",
             len, bad, gaps, load_done, load_error, words_loaded);
  endtask

  initial begin
    logic [15:0] w[$];
    int len;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(posedge clk);
    #1;
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("rst_we_b", 32'(bus.we_b), 32'd0);
    check("rst_data_b", 32'(bus.data_b), 32'd0);
    check("rst_addr_b", 32'(bus.addr_b), 32'(BASE));
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_flags", 32'({load_done, load_error}), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    do_reset();

    w = '{16'h1234, 16'hABCD};
    run_frame(2, w, 1'b0, 1'b0);
    run_frame(2, w, 1'b1, 1'b0);
    w = {};
    run_frame(16'h0401, w, 1'b0, 1'b0);
    run_frame(0, w, 1'b0, 1'b0);

    // Stall after one data byte: load_error must appear exactly TMO cycles later.
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    bus.rx_valid = 1'b0;
    repeat (TMO - 1) @(posedge clk);
    #1;
    check("timeout_not_yet", 32'(load_error), 32'd0);
    @(posedge clk);
    #1;
    check("timeout_error", 32'(load_error), 32'd1);
    check("timeout_hold", 32'(cpu_hold), 32'd0);
    $display("timeout frame error=%0d", load_error);

    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check("garbage_ignored", 32'(cpu_hold), 32'd0);
    w = '{16'hBEEF, 16'h0001, 16'hA5A5};
    run_frame(3, w, 1'b0, 1'b1);

    // Reset arrives while the low byte is being offered.
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    bus.rx_data  = 8'h34;
    bus.rx_valid = 1'b1;
    reset        = 1'b1;
    mon_en       = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_we_b", 32'(bus.we_b), 32'd0);
    check("midrst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("midrst_words", 32'(words_loaded), 32'd0);
    check("midrst_addr", 32'(bus.addr_b), 32'(BASE));
    $display("mid-frame reset hold=%0d we=%0d", cpu_hold, bus.we_b);
    do_reset();

    for (int f = 0; f < 10; f++) begin
      w   = {};
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) w.push_back(16'($urandom));
      run_frame(len, w, ($urandom_range(0, 3) == 0), f[0]);
    end

    w = {};
    for (int i = 0; i < MAXW; i++) w.push_back(16'($urandom));
    run_frame(MAXW, w, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got no finish required finish");
    $fatal(1, "global timeout");
  end

endmodule
